// File: rtl/return_address_stack_pkg.sv
// Shared processor constants: PC width and return-address-stack geometry,
// plus the stack operation decode used by the control logic.
package return_address_stack_pkg;

  localparam int PC_W      = 6;
  localparam int RAS_AW    = PC_W;
  localparam int RAS_DEPTH = 8;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {
    RAS_IDLE,
    RAS_PUSH,
    RAS_POP,
    RAS_REPLACE
  } ras_op_e;

  // A CALL and RET in the same cycle swap the top entry, but only when there
  // is a top entry; on an empty stack it degrades to a plain push.
  function automatic ras_op_e ras_decode(input logic push, input logic pop,
                                         input logic empty);
    if (push && pop && !empty) return RAS_REPLACE;
    if (push)                  return RAS_PUSH;
    if (pop)                   return RAS_POP;
    return RAS_IDLE;
  endfunction

endpackage

// File: rtl/ras_storage.sv
// DEPTH x AW register file for the return address stack: one synchronous
// write port and two asynchronous read ports.
module ras_storage
  import return_address_stack_pkg::*;
#(
  parameter int AW    = RAS_AW,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic                     Clk,
  input  logic                     WrEn,
  input  logic [$clog2(DEPTH)-1:0] WrPtr,
  input  logic [AW-1:0]            WrData,
  input  logic [$clog2(DEPTH)-1:0] RdPtrA,
  output logic [AW-1:0]            RdDataA,
  input  logic [$clog2(DEPTH)-1:0] RdPtrB,
  output logic [AW-1:0]            RdDataB
);

  logic [AW-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the control logic never exposes an entry
  // that has not been written since reset, so clearing it buys nothing.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clk) begin
    if (WrEn) mem[WrPtr] <= WrData;
  end

  assign RdDataA = mem[RdPtrA];
  assign RdDataB = mem[RdPtrB];

endmodule

// File: rtl/return_address_stack.sv
// Return address stack: circular buffer of return PCs with registered top,
// occupancy count and sticky overflow/underflow flags.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int AW    = RAS_AW,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Push,
  input  logic [AW-1:0]          PushAddr,
  input  logic                   Pop,
  input  logic                   ClrErr,
  output logic [AW-1:0]          TopAddr,
  output logic                   Empty,
  output logic                   Full,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   TWO_CNT  = (PW+1)'(2);

  logic [PW-1:0] wptr, wptr_nxt, ptr_m1, ptr_m2, wr_ptr;
  logic [PW:0]   count_q, count_nxt;
  logic [AW-1:0] top_nxt, rd_m1, rd_m2;
  logic          wr_en, set_ovf, set_unf, ovf_nxt, unf_nxt;
  ras_op_e       op;

  assign ptr_m1 = wptr - PW'(1);
  assign ptr_m2 = wptr - PW'(2);

  assign Count = count_q;
  assign Empty = (count_q == '0);
  assign Full  = (count_q == FULL_CNT);

  ras_storage #(.AW(AW), .DEPTH(DEPTH)) u_storage (
    .Clk     (Clk),
    .WrEn    (wr_en),
    .WrPtr   (wr_ptr),
    .WrData  (PushAddr),
    .RdPtrA  (ptr_m1),
    .RdDataA (rd_m1),
    .RdPtrB  (ptr_m2),
    .RdDataB (rd_m2)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    op        = ras_decode(Push, Pop, Empty);
    wptr_nxt  = wptr;
    count_nxt = count_q;
    top_nxt   = Empty ? '0 : rd_m1;
    wr_en     = 1'b0;
    wr_ptr    = wptr;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;

    unique case (op)
      RAS_PUSH: begin
        wr_en    = 1'b1;
        wptr_nxt = wptr + PW'(1);
        top_nxt  = PushAddr;
        set_unf  = Pop;
        // When full the oldest entry is overwritten and the count saturates.
        if (Full) set_ovf   = 1'b1;
        else      count_nxt = count_q + (PW+1)'(1);
      end
      RAS_REPLACE: begin
        wr_en   = 1'b1;
        wr_ptr  = ptr_m1;
        top_nxt = PushAddr;
      end
      RAS_POP: begin
        if (Empty) begin
          set_unf = 1'b1;
        end else begin
          wptr_nxt  = ptr_m1;
          count_nxt = count_q - (PW+1)'(1);
          top_nxt   = (count_q >= TWO_CNT) ? rd_m2 : '0;
        end
      end
      default: ;
    endcase

    // A new error in the clearing cycle keeps the flag set.
    ovf_nxt = set_ovf | (Overflow  & ~ClrErr);
    unf_nxt = set_unf | (Underflow & ~ClrErr);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wptr      <= '0;
      count_q   <= '0;
      TopAddr   <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      count_q   <= count_nxt;
      TopAddr   <= top_nxt;
      Overflow  <= ovf_nxt;
      Underflow <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: directed vector table,
// hand-written corner sequences and random traffic against a queue model.
module tb_return_address_stack;

  localparam int AW    = 6;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Push, Pop, ClrErr;
  logic [AW-1:0] PushAddr;
  logic [AW-1:0] TopAddr;
  logic          Empty, Full, Overflow, Underflow;
  logic [CW-1:0] Count;

  int n_checks = 0;
  int n_pass   = 0;

  return_address_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Push      (Push),
    .PushAddr  (PushAddr),
    .Pop       (Pop),
    .ClrErr    (ClrErr),
    .TopAddr   (TopAddr),
    .Empty     (Empty),
    .Full      (Full),
    .Count     (Count),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a bounded list of live return addresses, newest last.
  int unsigned mq[$];
  bit m_ovf, m_unf;

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit push, input int unsigned addr,
                            input bit pop, input bit clr);
    bit so, su;
    so = 1'b0;
    su = 1'b0;
    if (push && pop && mq.size() > 0) begin
      mq[mq.size()-1] = addr;
    end else if (push) begin
      if (mq.size() == DEPTH) begin
        void'(mq.pop_front());
        so = 1'b1;
      end
      mq.push_back(addr);
      if (pop) su = 1'b1;
    end else if (pop) begin
      if (mq.size() == 0) su = 1'b1;
      else void'(mq.pop_back());
    end
    m_ovf = so | (m_ovf & !clr);
    m_unf = su | (m_unf & !clr);
  endtask

  function automatic int unsigned model_top();
    return (mq.size() == 0) ? 0 : mq[mq.size()-1];
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".top"},   int'(TopAddr),   int'(model_top()));
    check({tag, ".count"}, int'(Count),     mq.size());
    check({tag, ".empty"}, int'(Empty),     int'(mq.size() == 0));
    check({tag, ".full"},  int'(Full),      int'(mq.size() == DEPTH));
    check({tag, ".ovf"},   int'(Overflow),  int'(m_ovf));
    check({tag, ".unf"},   int'(Underflow), int'(m_unf));
  endtask

  // Drive one cycle of stimulus, step the model, sample #1 after the edge.
  task automatic cycle(input bit push, input int unsigned addr,
                       input bit pop, input bit clr);
    Push     = push;
    PushAddr = AW'(addr);
    Pop      = pop;
    ClrErr   = clr;
    model_step(push, addr, pop, clr);
    @(posedge Clk);
    #1;
    Push   = 1'b0;
    Pop    = 1'b0;
    ClrErr = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n  = 1'b0;
    Push     = 1'b0;
    Pop      = 1'b0;
    ClrErr   = 1'b0;
    PushAddr = '0;
    model_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic          push;
    logic [AW-1:0] addr;
    logic          pop;
    logic          clr;
    logic [AW-1:0] top;
    logic [CW-1:0] cnt;
    logic          emp;
    logic          ful;
    logic          ovf;
    logic          unf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    Reset_n = 1'b0;
    Push = 1'b0; Pop = 1'b0; ClrErr = 1'b0; PushAddr = '0;
    #3;
    check("reset.top",   int'(TopAddr),   0);
    check("reset.count", int'(Count),     0);
    check("reset.empty", int'(Empty),     1);
    check("reset.full",  int'(Full),      0);
    check("reset.ovf",   int'(Overflow),  0);
    check("reset.unf",   int'(Underflow), 0);
    do_reset();

    //          push addr  pop clr  top cnt emp ful ovf unf
    vecs.push_back({1'b1, 6'd5,  1'b0, 1'b0, 6'd5,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b1, 6'd12, 1'b0, 1'b0, 6'd12, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b1, 6'd33, 1'b0, 1'b0, 6'd33, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 6'd0,  1'b1, 1'b0, 6'd12, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 6'd0,  1'b1, 1'b0, 6'd5,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back({1'b0, 6'd0,  1'b0, 1'b1, 6'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back({1'b0, 6'd0,  1'b1, 1'b1, 6'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back({1'b0, 6'd0,  1'b0, 1'b1, 6'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b1, 6'd9,  1'b0, 1'b0, 6'd9,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b1, 6'd10, 1'b0, 1'b0, 6'd10, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b1, 6'd20, 1'b1, 1'b0, 6'd20, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 6'd0,  1'b1, 1'b0, 6'd9,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b1, 6'd44, 1'b1, 1'b0, 6'd44, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back({1'b0, 6'd0,  1'b1, 1'b1, 6'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      cycle(vecs[i].push, vecs[i].addr, vecs[i].pop, vecs[i].clr);
      check($sformatf("vec%0d.top", i),   int'(TopAddr),   int'(vecs[i].top));
      check($sformatf("vec%0d.count", i), int'(Count),     int'(vecs[i].cnt));
      check($sformatf("vec%0d.empty", i), int'(Empty),     int'(vecs[i].emp));
      check($sformatf("vec%0d.full", i),  int'(Full),      int'(vecs[i].ful));
      check($sformatf("vec%0d.ovf", i),   int'(Overflow),  int'(vecs[i].ovf));
      check($sformatf("vec%0d.unf", i),   int'(Underflow), int'(vecs[i].unf));
    end

    // Fill, overflow by one, then drain past the overwritten oldest entry.
    do_reset();
    for (int a = 1; a <= 8; a++) cycle(1'b1, a, 1'b0, 1'b0);
    check("fill.full_before_9th", int'(Full), 1);
    cycle(1'b1, 63, 1'b0, 1'b0);
    check("ovf.flag",  int'(Overflow), 1);
    check("ovf.count", int'(Count),    8);
    check("ovf.top",   int'(TopAddr),  63);
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 0, 1'b1, 1'b0);
      check($sformatf("drain%0d.top", k), int'(TopAddr), (k == 8) ? 0 : 9 - k);
    end
    check("drain.empty", int'(Empty), 1);
    check("drain.unf",   int'(Underflow), 0);
    check("drain.ovf_sticky", int'(Overflow), 1);

    // Asynchronous reset in the middle of a clock period.
    do_reset();
    cycle(1'b1, 3, 1'b0, 1'b0);
    cycle(1'b1, 4, 1'b0, 1'b0);
    cycle(1'b1, 5, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 11, 1'b0, 1'b0);
    cycle(1'b1, 12, 1'b0, 1'b0);
    cycle(1'b1, 13, 1'b0, 1'b0);
    check("pre_async.count", int'(Count), 3);
    check("pre_async.unf",   int'(Underflow), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_model("async");
    #1;
    Reset_n = 1'b1;
    cycle(1'b1, 7, 1'b0, 1'b0);
    check("post_async.count", int'(Count),   1);
    check("post_async.top",   int'(TopAddr), 7);

    // Random traffic against the queue model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit p, q, c;
      int unsigned r;
      r = $urandom_range(0, 99);
      p = (r < 55);
      q = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 10);
      cycle(p, $urandom_range(0, 63), q, c);
      check_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/return_address_stack.md
RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 SHALL have parameter AW, default 6, address width matching the 6-bit program counter.
REQ-002 SHALL have parameter DEPTH, default 8, number of stack entries (power of two, >= 2).
REQ-003 SHALL have port Clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Push, input, 1, CALL executed: store PushAddr (the incremented PC) this cycle.
REQ-006 SHALL have port PushAddr, input, AW, return address to store.
REQ-007 SHALL have port Pop, input, 1, RET executed: remove top entry this cycle.
REQ-008 SHALL have port ClrErr, input, 1, clears sticky error flags.
REQ-009 SHALL have port TopAddr, output, AW, registered top-of-stack address; 0 when empty.
REQ-010 SHALL have port Empty, output, 1, high when Count == 0.
REQ-011 SHALL have port Full, output, 1, high when Count == DEPTH.
REQ-012 SHALL have port Count, output, log2(DEPTH)+1, number of valid entries.
REQ-013 SHALL have port Overflow, output, 1, sticky: a push occurred while Full.
REQ-014 SHALL have port Underflow, output, 1, sticky: a pop occurred while Empty.

Function
REQ-015 SHALL store entries in a circular buffer indexed by a log2(DEPTH)-bit write pointer WPtr; top = entry[WPtr-1], modulo DEPTH.
REQ-016 Push only, not Full: entry[WPtr] <= PushAddr, WPtr +1, Count +1, TopAddr <= PushAddr at the same edge (1-cycle latency).
REQ-017 Push only, Full: entry[WPtr] <= PushAddr (overwrites oldest), WPtr +1 (wraps), Count stays DEPTH, Overflow <= 1, TopAddr <= PushAddr.
REQ-018 Pop only, Count >= 2: WPtr -1, Count -1, TopAddr <= entry[WPtr-2].
REQ-019 Pop only, Count == 1: WPtr -1, Count <= 0, TopAddr <= 0.
REQ-020 Pop only, Empty: no pointer/count/memory change, TopAddr stays 0, Underflow <= 1.
REQ-021 Push and Pop, not Empty: top entry replaced, entry[WPtr-1] <= PushAddr, WPtr and Count unchanged, TopAddr <= PushAddr, no flag change.
REQ-022 Push and Pop, Empty: behaves as push only (Count <= 1, TopAddr <= PushAddr) and Underflow <= 1.
REQ-023 ClrErr SHALL clear Overflow and Underflow at the next edge; a flag-setting event in the same cycle wins (flag remains 1).
REQ-024 Empty, Full and Count SHALL be derived from the registered Count only; no combinational path from Push/Pop to any output.
REQ-025 Pointer and Count arithmetic SHALL wrap modulo DEPTH and 2*DEPTH respectively, with no X propagation from unwritten entries (TopAddr forced 0 when Empty).

Reset
REQ-026 On Reset_n low, asynchronously: WPtr=0, Count=0, TopAddr=0, Overflow=0, Underflow=0; Empty=1, Full=0.
REQ-027 Storage entries SHALL NOT require reset; they are never observable while invalid.
REQ-028 Reset asserted mid-operation SHALL discard all entries; the first edge after deassertion behaves as on an empty stack.

Structure
REQ-029 AW, DEPTH default and the derived pointer width SHALL live in the shared processor constants package alongside the PC width.
REQ-030 Storage SHALL be a single sub-module ras_storage (DEPTH x AW register file, one write port, two read ports at WPtr-1 and WPtr-2); control stays in the top.

Verification
REQ-031 Reset, then Push 6'd5, 6'd12, 6'd33 on consecutive cycles -> TopAddr 5, 12, 33 one edge after each push; Count=3; Empty=0.
REQ-032 Continue: Pop x3 -> TopAddr 12, 5, 0; Count 2, 1, 0; Empty=1 after the third; Underflow=0.
REQ-033 Push 1..8 then Push 6'd63 -> Full=1 before the 9th push; after it Overflow=1, Count=8, TopAddr=63; 8 pops return 63,8,7,6,5,4,3,2, then 0 with Empty=1.
REQ-034 Empty stack, Pop -> Underflow=1, Count=0, TopAddr=0; ClrErr with no error in the same cycle -> Underflow=0 next edge; ClrErr plus Pop on Empty -> Underflow stays 1.
REQ-035 Count=2 (top 6'd10), Push 6'd20 with Pop -> TopAddr=20, Count=2; then Pop -> TopAddr equals the entry below (first pushed value).
REQ-036 Reset_n pulsed low between edges with Count=3 -> all outputs at reset values immediately (without a clock edge); next Push 6'd7 -> Count=1, TopAddr=7.
